// File: rtl/fifo_pop_ctrl.sv
// fifo_pop_ctrl: read stage behind the synchronous FIFO.
// Issues pops, absorbs the FIFO's one-cycle read latency in a 3-entry skid
// buffer and presents words on a valid/ready interface.
module fifo_pop_ctrl #(
  parameter int unsigned BITNUMBER = 8,
  parameter int unsigned CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 fifo_empty,
  input  logic [BITNUMBER-1:0] fifo_data_out,
  output logic                 fifo_rd,
  output logic [BITNUMBER-1:0] data_out,
  output logic                 valid_out,
  input  logic                 ready_in,
  output logic [CNT_W-1:0]     pop_count
);

  localparam int unsigned DEPTH  = 3;
  localparam int unsigned OCC_W  = 2;
  localparam int unsigned FILL_W = 3;

  logic [OCC_W-1:0]     r_occ;
  logic                 r_inflight;
  logic [BITNUMBER-1:0] r_buf [DEPTH];
  logic [CNT_W-1:0]     r_pop_count;

  logic [FILL_W-1:0]    w_fill;
  logic                 w_xfer;
  logic [OCC_W-1:0]     w_base;
  logic [OCC_W-1:0]     w_occ_nxt;
  logic [BITNUMBER-1:0] w_buf_nxt [DEPTH];

  // Words held plus the one still coming out of the FIFO; a pop is only
  // issued while there is guaranteed room for its word.
  assign w_fill    = FILL_W'(r_occ) + FILL_W'(r_inflight);
  assign fifo_rd   = reset & ~fifo_empty & (w_fill < FILL_W'(DEPTH));
  assign valid_out = (r_occ != '0);
  assign data_out  = r_buf[0];
  assign w_xfer    = valid_out & ready_in;
  assign pop_count = r_pop_count;

  // Next buffer contents: shift out the head on a transfer, then append
  // the arriving word at the first free slot.
  always_comb begin
    w_buf_nxt = r_buf;
    w_base    = r_occ;
    w_occ_nxt = r_occ;
    if (w_xfer) begin
      for (int unsigned i = 0; i < DEPTH - 1; i++) begin
        w_buf_nxt[i] = r_buf[i+1];
      end
      w_base = r_occ - OCC_W'(1);
    end
    w_occ_nxt = w_base;
    if (r_inflight) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (OCC_W'(i) == w_base) begin
          w_buf_nxt[i] = fifo_data_out;
        end
      end
      w_occ_nxt = w_base + OCC_W'(1);
    end
  end

  // State register; reset drops any read in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_occ       <= '0;
      r_inflight  <= 1'b0;
      r_pop_count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_buf[i] <= '0;
      end
    end else begin
      r_occ      <= w_occ_nxt;
      r_inflight <= fifo_rd;
      r_buf      <= w_buf_nxt;
      if (w_xfer) begin
        r_pop_count <= r_pop_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fifo_pop_ctrl.sv
// Testbench for fifo_pop_ctrl: behavioural FIFO source plus a word-level
// scoreboard (words popped vs. words delivered) checked every cycle.
module tb_fifo_pop_ctrl;

  localparam int unsigned BW = 8;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          fifo_empty;
  logic [BW-1:0] fifo_data_out;
  logic          fifo_rd;
  logic [BW-1:0] data_out;
  logic          valid_out;
  logic          ready_in;
  logic [CW-1:0] pop_count;

  fifo_pop_ctrl #(.BITNUMBER(BW), .CNT_W(CW)) dut (
    .clk           (clk),
    .reset         (reset),
    .fifo_empty    (fifo_empty),
    .fifo_data_out (fifo_data_out),
    .fifo_rd       (fifo_rd),
    .data_out      (data_out),
    .valid_out     (valid_out),
    .ready_in      (ready_in),
    .pop_count     (pop_count)
  );

  always #5 clk = ~clk;

  // FIFO contents not yet popped, and popped words not yet delivered.
  logic [BW-1:0] src_q[$];
  logic [BW-1:0] exp_q[$];
  int unsigned   n_rd;
  int unsigned   n_xfer;
  logic          last_rd;
  logic          gate_empty;
  int            n_tests;
  int            n_fail;

  // One clock cycle: drive inputs, check outputs against the model, advance.
  task automatic step(input logic rdy, output logic o_rd, output logic o_valid,
                      output logic [BW-1:0] o_data);
    int unsigned   outst;
    int unsigned   capt;
    logic          exp_rd;
    logic [CW-1:0] exp_cnt;
    logic [BW-1:0] w;
    @(negedge clk);
    ready_in   = rdy;
    fifo_empty = gate_empty || (src_q.size() == 0);
    #1;
    o_rd    = fifo_rd;
    o_valid = valid_out;
    o_data  = data_out;
    outst   = n_rd - n_xfer;
    capt    = outst - int'(last_rd);
    exp_rd  = reset && !fifo_empty && (outst < 3);
    exp_cnt = CW'(n_xfer);
    n_tests++;
    if (fifo_rd !== exp_rd) begin
      n_fail++;
      $display("FAIL fifo_rd t=%0t got %b exp %b", $time, fifo_rd, exp_rd);
    end
    n_tests++;
    if (valid_out !== (capt != 0)) begin
      n_fail++;
      $display("FAIL valid_out t=%0t got %b exp %b", $time, valid_out, capt != 0);
    end
    if (capt != 0) begin
      n_tests++;
      if (data_out !== exp_q[0]) begin
        n_fail++;
        $display("FAIL data_out t=%0t got %h exp %h", $time, data_out, exp_q[0]);
      end
    end
    if (!reset) begin
      n_tests++;
      if (data_out !== '0) begin
        n_fail++;
        $display("FAIL data_out_rst t=%0t got %h exp 00", $time, data_out);
      end
    end
    n_tests++;
    if (pop_count !== exp_cnt) begin
      n_fail++;
      $display("FAIL pop_count t=%0t got %0d exp %0d", $time, pop_count, exp_cnt);
    end
    @(posedge clk);
    #1;
    if (reset) begin
      if (o_valid === 1'b1 && rdy) begin
        void'(exp_q.pop_front());
        n_xfer++;
      end
      if (o_rd === 1'b1 && src_q.size() != 0) begin
        w = src_q.pop_front();
        fifo_data_out = w;
        exp_q.push_back(w);
        n_rd++;
      end
      last_rd = (o_rd === 1'b1);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    n_rd    = 0;
    n_xfer  = 0;
    last_rd = 1'b0;
  endtask

  task automatic do_reset();
    logic r, v;
    logic [BW-1:0] d;
    reset      = 1'b0;
    gate_empty = 1'b0;
    src_q.delete();
    model_clear();
    step(1'b0, r, v, d);
    step(1'b0, r, v, d);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    logic r, v;
    logic [BW-1:0] d;
    reset = 1'b0;
    model_clear();
    src_q.delete();
    gate_empty = 1'b0;
    for (int i = 0; i < 4; i++) src_q.push_back(BW'($urandom));
    for (int c = 0; c < 2; c++) begin
      step(1'b1, r, v, d);
      n_tests++;
      if (r !== 1'b0 || v !== 1'b0 || d !== '0 || pop_count !== '0) begin
        n_fail++;
        $display("FAIL reset_state rd=%b valid=%b data=%h cnt=%0d exp 0,0,00,0", r, v, d, pop_count);
      end
    end
    reset = 1'b1;
  endtask

  task automatic test_streaming();
    logic r, v;
    logic [BW-1:0] d;
    logic [BW-1:0] words[4];
    logic rd_h[10];
    logic vl_h[10];
    logic [BW-1:0] dt_h[10];
    do_reset();
    for (int i = 0; i < 4; i++) begin
      words[i] = BW'($urandom);
      src_q.push_back(words[i]);
    end
    for (int c = 0; c < 10; c++) begin
      step(1'b1, r, v, d);
      rd_h[c] = r; vl_h[c] = v; dt_h[c] = d;
    end
    for (int c = 0; c < 5; c++) begin
      n_tests++;
      if (rd_h[c] !== (c < 4)) begin
        n_fail++;
        $display("FAIL stream_rd cycle %0d got %b exp %b", c, rd_h[c], c < 4);
      end
    end
    for (int c = 0; c < 7; c++) begin
      n_tests++;
      if (vl_h[c] !== (c >= 2 && c < 6)) begin
        n_fail++;
        $display("FAIL stream_valid cycle %0d got %b exp %b", c, vl_h[c], c >= 2 && c < 6);
      end
      if (c >= 2 && c < 6) begin
        n_tests++;
        if (dt_h[c] !== words[c-2]) begin
          n_fail++;
          $display("FAIL stream_data cycle %0d got %h exp %h", c, dt_h[c], words[c-2]);
        end
      end
    end
    n_tests++;
    if (pop_count !== CW'(4)) begin
      n_fail++;
      $display("FAIL stream_count got %0d exp 4", pop_count);
    end
  endtask

  task automatic test_backpressure();
    logic r, v;
    logic [BW-1:0] d;
    int   rd_cnt;
    int   got_cnt;
    logic started;
    do_reset();
    for (int i = 1; i <= 8; i++) src_q.push_back(BW'(i));
    rd_cnt = 0;
    for (int c = 0; c < 8; c++) begin
      step(1'b0, r, v, d);
      if (r === 1'b1) rd_cnt++;
      if (v === 1'b1) begin
        n_tests++;
        if (d !== BW'(1)) begin
          n_fail++;
          $display("FAIL stall_data cycle %0d got %h exp 01", c, d);
        end
      end
    end
    n_tests++;
    if (rd_cnt != 3) begin
      n_fail++;
      $display("FAIL stall_rd_pulses got %0d exp 3", rd_cnt);
    end
    got_cnt = 0;
    started = 1'b0;
    for (int c = 0; c < 30 && got_cnt < 8; c++) begin
      step(1'b1, r, v, d);
      if (v === 1'b1) begin
        started = 1'b1;
        got_cnt++;
        n_tests++;
        if (d !== BW'(got_cnt)) begin
          n_fail++;
          $display("FAIL bp_order got %h exp %h", d, BW'(got_cnt));
        end
      end else if (started) begin
        n_tests++;
        n_fail++;
        $display("FAIL bp_gap cycle %0d got valid=0 exp valid=1", c);
      end
    end
    n_tests++;
    if (got_cnt != 8 || pop_count !== CW'(8)) begin
      n_fail++;
      $display("FAIL bp_count got %0d words cnt=%0d exp 8 words cnt=8", got_cnt, pop_count);
    end
  endtask

  task automatic test_empty_gating();
    logic r, v;
    logic [BW-1:0] d;
    logic [BW-1:0] seq[4];
    logic [BW-1:0] got[$];
    seq[0] = 8'h0E; seq[1] = 8'h0F; seq[2] = 8'h01; seq[3] = 8'h02;
    do_reset();
    for (int i = 0; i < 4; i++) src_q.push_back(seq[i]);
    for (int c = 0; c < 30; c++) begin
      gate_empty = ((c / 2) % 2) == 0;
      step(1'b1, r, v, d);
      if (fifo_empty) begin
        n_tests++;
        if (r !== 1'b0) begin
          n_fail++;
          $display("FAIL gate_rd cycle %0d got %b exp 0", c, r);
        end
      end
      if (v === 1'b1) got.push_back(d);
    end
    gate_empty = 1'b0;
    n_tests++;
    if (got.size() != 4) begin
      n_fail++;
      $display("FAIL gate_count got %0d exp 4", got.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_tests++;
        if (got[i] !== seq[i]) begin
          n_fail++;
          $display("FAIL gate_seq idx %0d got %h exp %h", i, got[i], seq[i]);
        end
      end
    end
  endtask

  task automatic test_midstream_reset();
    logic r, v;
    logic [BW-1:0] d;
    logic [BW-1:0] next_w;
    logic seen;
    do_reset();
    for (int i = 0; i < 8; i++) src_q.push_back(BW'($urandom));
    for (int c = 0; c < 3; c++) step(1'b0, r, v, d);
    reset = 1'b0;
    #1;
    n_tests++;
    if (valid_out !== 1'b0 || fifo_rd !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_immediate valid=%b rd=%b exp 0,0", valid_out, fifo_rd);
    end
    model_clear();
    next_w = src_q[0];
    step(1'b1, r, v, d);
    reset = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      step(1'b1, r, v, d);
      if (v === 1'b1) begin
        seen = 1'b1;
        n_tests++;
        if (d !== next_w) begin
          n_fail++;
          $display("FAIL midrst_first got %h exp %h", d, next_w);
        end
      end
    end
    n_tests++;
    if (!seen || pop_count !== CW'(1)) begin
      n_fail++;
      $display("FAIL midrst_restart seen=%b cnt=%0d exp seen=1 cnt=1", seen, pop_count);
    end
  endtask

  task automatic test_wrap();
    logic r, v;
    logic [BW-1:0] d;
    do_reset();
    for (int i = 0; i < 17; i++) src_q.push_back(BW'($urandom));
    for (int c = 0; c < 60 && n_xfer < 17; c++) step(1'b1, r, v, d);
    n_tests++;
    if (n_xfer != 17 || pop_count !== CW'(1)) begin
      n_fail++;
      $display("FAIL wrap xfers=%0d cnt=%0d exp 17, 1", n_xfer, pop_count);
    end
  endtask

  task automatic test_random();
    logic r, v;
    logic [BW-1:0] d;
    int pushed;
    do_reset();
    pushed = 0;
    for (int c = 0; c < 400; c++) begin
      if (src_q.size() < 6 && $urandom_range(0, 1) == 1) begin
        src_q.push_back(BW'($urandom));
        pushed++;
      end
      gate_empty = ($urandom_range(0, 3) == 0);
      step($urandom_range(0, 9) < 7, r, v, d);
    end
    gate_empty = 1'b0;
    for (int c = 0; c < 60 && (src_q.size() != 0 || exp_q.size() != 0); c++) begin
      step(1'b1, r, v, d);
    end
    n_tests++;
    if (n_xfer != pushed) begin
      n_fail++;
      $display("FAIL random_total got %0d exp %0d", n_xfer, pushed);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    ready_in = 1'b0;
    fifo_empty = 1'b1;
    fifo_data_out = '0;
    gate_empty = 1'b0;
    reset = 1'b1;
    #1 reset = 1'b0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_empty_gating();
    test_midstream_reset();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
